// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe -- registered RV32I instruction-decode stage (ID/EX register).
//
// Decodes instr into the control encodings used by the rest of the pipeline
// (ALUOp / EXTOp / NPCOp / WDSel / DMType) and holds them in an ID/EX register.
// The register uses valid/ready flow control. The stage inserts a bubble on a
// load-use hazard and clears its contents on flush.
//
// Optional feature: define MULDIV_EN to decode the M extension. A mul/div op
// then holds off new instructions for MULDIV_LAT cycles in total, using a small
// IDLE/BUSY FSM. With MULDIV_EN undefined, M-extension encodings decode as
// illegal and md_busy is tied to 0.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   instr/pc handshake from IF (in_ready is combinational)
//   instr, pc_in        instruction word and its pc
//   ex_memread, ex_rd   load-in-EX information for the load-use hazard check
//   flush               kill the stage contents (taken branch/jump)
//   out_ready/out_valid ID/EX handshake with EX
//   pc_out, rs1/rs2/rd  registered pc and register fields
//   RegWrite..WDSel     registered control signals
//   illegal             registered: instruction is not in the supported set
//   md_busy             multi-cycle mul/div op in progress
module decode_ctrl_pipe #(
  parameter int XLEN       = 32,
  parameter int MULDIV_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc_in,
  input  logic            ex_memread,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            RegWrite,
  output logic            MemWrite,
  output logic            MemRead,
  output logic            ALUSrc,
  output logic [4:0]      ALUOp,
  output logic [5:0]      EXTOp,
  output logic [2:0]      NPCOp,
  output logic [2:0]      DMType,
  output logic [1:0]      WDSel,
  output logic            illegal,
  output logic            md_busy
);

  // Opcodes
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // ALUOp encodings
  localparam logic [4:0] ALU_NOP   = 5'b00000;
  localparam logic [4:0] ALU_LUI   = 5'b00001;
  localparam logic [4:0] ALU_AUIPC = 5'b00010;
  localparam logic [4:0] ALU_ADD   = 5'b00011;
  localparam logic [4:0] ALU_SUB   = 5'b00100;
  localparam logic [4:0] ALU_BNE   = 5'b00101;
  localparam logic [4:0] ALU_BLT   = 5'b00110;
  localparam logic [4:0] ALU_BGE   = 5'b00111;
  localparam logic [4:0] ALU_BLTU  = 5'b01000;
  localparam logic [4:0] ALU_BGEU  = 5'b01001;
  localparam logic [4:0] ALU_SLT   = 5'b01010;
  localparam logic [4:0] ALU_SLTU  = 5'b01011;
  localparam logic [4:0] ALU_XOR   = 5'b01100;
  localparam logic [4:0] ALU_OR    = 5'b01101;
  localparam logic [4:0] ALU_AND   = 5'b01110;
  localparam logic [4:0] ALU_SLL   = 5'b01111;
  localparam logic [4:0] ALU_SRL   = 5'b10000;
  localparam logic [4:0] ALU_SRA   = 5'b10001;

  // EXTOp one-hot immediate formats
  localparam logic [5:0] EXT_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_I     = 6'b010000;
  localparam logic [5:0] EXT_S     = 6'b001000;
  localparam logic [5:0] EXT_B     = 6'b000100;
  localparam logic [5:0] EXT_U     = 6'b000010;
  localparam logic [5:0] EXT_J     = 6'b000001;

  localparam logic [2:0] NPC_PLUS4 = 3'b000;
  localparam logic [2:0] NPC_BR    = 3'b001;
  localparam logic [2:0] NPC_JAL   = 3'b010;
  localparam logic [2:0] NPC_JALR  = 3'b100;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_HU = 3'b010;
  localparam logic [2:0] DM_B  = 3'b011;
  localparam logic [2:0] DM_BU = 3'b100;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_write;
    logic            mem_read;
    logic            alu_src;
    logic [4:0]      alu_op;
    logic [5:0]      ext_op;
    logic [2:0]      npc_op;
    logic [2:0]      dm_type;
    logic [1:0]      wd_sel;
    logic            illegal;
  } idex_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  idex_t dec;
  idex_t q;
  logic  ill;
  logic  use_rs1;
  logic  use_rs2;
  logic  is_md;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  always_comb begin
    dec     = '0;
    ill     = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    is_md   = 1'b0;
    dec.pc  = pc_in;
    dec.rs1 = instr[19:15];
    dec.rs2 = instr[24:20];
    dec.rd  = instr[11:7];
    unique case (opcode)
      OP_R: begin
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        dec.reg_write = 1'b1;
        dec.wd_sel    = WD_ALU;
        if (funct7 == 7'b0000000) begin
          unique case (funct3)
            3'b000:  dec.alu_op = ALU_ADD;
            3'b001:  dec.alu_op = ALU_SLL;
            3'b010:  dec.alu_op = ALU_SLT;
            3'b011:  dec.alu_op = ALU_SLTU;
            3'b100:  dec.alu_op = ALU_XOR;
            3'b101:  dec.alu_op = ALU_SRL;
            3'b110:  dec.alu_op = ALU_OR;
            default: dec.alu_op = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec.alu_op = ALU_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec.alu_op = ALU_SRA;
`ifdef MULDIV_EN
        end else if (funct7 == 7'b0000001) begin
          is_md      = 1'b1;
          // mul..remu occupy 10010..11001 in funct3 order
          dec.alu_op = 5'b10010 + {2'b00, funct3};
`endif
        end else begin
          ill = 1'b1;
        end
      end
      OP_I: begin
        use_rs1       = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.ext_op    = EXT_I;
        unique case (funct3)
          3'b000: dec.alu_op = ALU_ADD;
          3'b010: dec.alu_op = ALU_SLT;
          3'b011: dec.alu_op = ALU_SLTU;
          3'b100: dec.alu_op = ALU_XOR;
          3'b110: dec.alu_op = ALU_OR;
          3'b111: dec.alu_op = ALU_AND;
          3'b001: begin
            dec.ext_op = EXT_SHAMT;
            dec.alu_op = ALU_SLL;
            ill        = (funct7 != 7'b0000000);
          end
          default: begin // 3'b101: srli / srai
            dec.ext_op = EXT_SHAMT;
            if (funct7 == 7'b0000000)      dec.alu_op = ALU_SRL;
            else if (funct7 == 7'b0100000) dec.alu_op = ALU_SRA;
            else                           ill = 1'b1;
          end
        endcase
      end
      OP_LOAD: begin
        use_rs1       = 1'b1;
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.alu_src   = 1'b1;
        dec.ext_op    = EXT_I;
        dec.alu_op    = ALU_ADD;
        dec.wd_sel    = WD_MEM;
        unique case (funct3)
          3'b000:  dec.dm_type = DM_B;
          3'b001:  dec.dm_type = DM_H;
          3'b010:  dec.dm_type = DM_W;
          3'b100:  dec.dm_type = DM_BU;
          3'b101:  dec.dm_type = DM_HU;
          default: ill = 1'b1;
        endcase
      end
      OP_STORE: begin
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.ext_op    = EXT_S;
        dec.alu_op    = ALU_ADD;
        unique case (funct3)
          3'b000:  dec.dm_type = DM_B;
          3'b001:  dec.dm_type = DM_H;
          3'b010:  dec.dm_type = DM_W;
          default: ill = 1'b1;
        endcase
      end
      OP_BR: begin
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        dec.ext_op = EXT_B;
        dec.npc_op = NPC_BR;
        unique case (funct3)
          3'b000:  dec.alu_op = ALU_SUB;   // beq compares via subtract
          3'b001:  dec.alu_op = ALU_BNE;
          3'b100:  dec.alu_op = ALU_BLT;
          3'b101:  dec.alu_op = ALU_BGE;
          3'b110:  dec.alu_op = ALU_BLTU;
          3'b111:  dec.alu_op = ALU_BGEU;
          default: ill = 1'b1;
        endcase
      end
      OP_JAL: begin
        dec.reg_write = 1'b1;
        dec.ext_op    = EXT_J;
        dec.npc_op    = NPC_JAL;
        dec.wd_sel    = WD_PC;
      end
      OP_JALR: begin
        use_rs1       = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.ext_op    = EXT_I;
        dec.alu_op    = ALU_ADD;
        dec.npc_op    = NPC_JALR;
        dec.wd_sel    = WD_PC;
        ill           = (funct3 != 3'b000);
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.ext_op    = EXT_U;
        dec.alu_op    = ALU_LUI;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.ext_op    = EXT_U;
        dec.alu_op    = ALU_AUIPC;
      end
      default: ill = 1'b1;
    endcase
    // An illegal instruction keeps its fields but has no side effects.
    if (ill) begin
      dec.reg_write = 1'b0;
      dec.mem_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.alu_src   = 1'b0;
      dec.alu_op    = ALU_NOP;
      dec.ext_op    = '0;
      dec.npc_op    = NPC_PLUS4;
      dec.dm_type   = DM_W;
      dec.wd_sel    = WD_ALU;
      dec.illegal   = 1'b1;
      use_rs1       = 1'b0;
      use_rs2       = 1'b0;
      is_md         = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic       state;
  logic       fire_out;
  logic       hazard;
  logic       accept;

  assign fire_out = ~out_valid | out_ready;
  assign hazard   = in_valid & ex_memread & (ex_rd != 5'd0) &
                    ((use_rs1 & (ex_rd == dec.rs1)) | (use_rs2 & (ex_rd == dec.rs2)));
  assign in_ready = fire_out & ~hazard & ~flush & (state == IDLE);
  assign accept   = in_valid & in_ready;

`ifdef MULDIV_EN
  localparam int CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT + 1) : 1;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;

  // The counter runs independently of out_ready: a stalled EX does not
  // extend the mul/div occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else if (state == IDLE) begin
      if (accept && is_md && (MULDIV_LAT > 1)) begin
        state  <= BUSY;
        cnt    <= CNT_W'(MULDIV_LAT - 1);
        busy_q <= 1'b1;
      end
    end else begin
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        state  <= IDLE;
        busy_q <= 1'b0;
      end
    end
  end
  assign md_busy = busy_q;
`else
  assign state   = IDLE;
  assign md_busy = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // ID/EX register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid <= 1'b0;
      q         <= '0;
    end else if (fire_out) begin
      if (accept) begin
        out_valid <= 1'b1;
        q         <= dec;
      end else begin
        // Bubble: zeroed controls guarantee no write side effects.
        out_valid <= 1'b0;
        q         <= '0;
      end
    end
  end

  assign pc_out   = q.pc;
  assign rs1      = q.rs1;
  assign rs2      = q.rs2;
  assign rd       = q.rd;
  assign RegWrite = q.reg_write;
  assign MemWrite = q.mem_write;
  assign MemRead  = q.mem_read;
  assign ALUSrc   = q.alu_src;
  assign ALUOp    = q.alu_op;
  assign EXTOp    = q.ext_op;
  assign NPCOp    = q.npc_op;
  assign DMType   = q.dm_type;
  assign WDSel    = q.wd_sel;
  assign illegal  = q.illegal;

endmodule
